fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: the producer side of the fetchToDecode interface (fetch modport).
//  Owns the PC and issues single-outstanding reads to instruction memory with a valid/ready handshake.
//  Registers each returned word together with its PC, then hands both to the decoder.
//  Accepts PC redirects from execute (branch/jump) and flushes any in-flight or held instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded by reset
//  XLEN       32             PC / address width
//  ILEN       32             instruction width
// PORTS
//  clk             in   1     single clock, rising edge
//  rst_n           in   1     reset: synchronous, active-low
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request this cycle
//  imem_req_addr   out  XLEN  fetch address (word aligned)
//  imem_rsp_valid  in   1     read data valid (>=1 cycle after accepted request)
//  imem_rsp_data   in   ILEN  read data
//  redirect_valid  in   1     execute requests PC change
//  redirect_pc     in   XLEN  redirect target
//  dec_ready       in   1     decoder consumes next_* this cycle
//  next_valid      out  1     next_pc_reg/next_inst hold a valid instruction
//  next_pc_reg     out  XLEN  PC of held instruction (fetchToDecode.next_pc_reg)
//  next_inst       out  ILEN  held instruction word (fetchToDecode.next_inst)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): pc=RESET_PC, state=S_REQ, kill=0, next_valid=0,
//   next_pc_reg=0, next_inst=NOP (32'h0000_0013). imem_req_valid is forced to 0 while rst_n==0.
//  The output register is "free" when next_valid==0, or when next_valid&&dec_ready (consumed this cycle).
//  FSM:
//   S_REQ : imem_req_valid = free; imem_req_addr = pc.
//           On req_valid&&req_ready: go to S_WAIT; req_pc <= pc.
//   S_WAIT: imem_req_valid = 0. On rsp_valid:
//           - if kill: drop the data, kill <= 0.
//           - else: next_valid <= 1, next_pc_reg <= req_pc, next_inst <= rsp_data, pc <= req_pc + 4.
//           Then go to S_REQ.
//  Consume: next_valid&&dec_ready with no new load -> next_valid <= 0 next cycle.
//  Redirect has highest priority every cycle:
//   - pc <= {redirect_pc[XLEN-1:2], 2'b00}; next_valid <= 0 (held instruction flushed).
//   - In S_WAIT: kill <= 1, and the pending response is dropped. If rsp_valid arrives in the same
//     cycle as the redirect, drop it and go to S_REQ; do not set kill.
//   - In S_REQ with a handshake in the same cycle: go to S_WAIT with kill=1 (the old-PC request is in flight).
//   - A redirect while kill==1 only updates pc; exactly one response is still dropped.
//   - The pc+4 update from a response never overrides a same-cycle redirect.
//  Latency: request accepted at t, response at t+1 -> next_valid=1 at t+2.
//   Peak throughput is 1 instruction per 2 cycles (single outstanding request).
//  Arithmetic: pc + 4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0). imem_req_addr[1:0] is always 2'b00.
//  next_* are stable while next_valid && !dec_ready. The unit never issues a second request before a response.
//  Reset mid-operation: an outstanding response is lost. imem must ignore/flush on reset; fetch returns to RESET_PC.
// STRUCTURE
//  fetch_pkg: typedef enum logic {S_REQ, S_WAIT} fetch_state_t; localparam NOP_INST = 32'h0000_0013;
//   default RESET_PC constant. Widen the fetchToDecode interface with next_valid and dec_ready.
//  One sub-module, fetch_pc_gen: pc register with redirect/increment priority mux and alignment.
//   FSM, kill flag and output register stay in fetch_unit.
// TESTING
//  1 Reset, imem_req_ready=1, 1-cycle rsp, dec_ready=1 -> addrs 0x0,0x4,0x8; next_pc_reg 0,4,8 every 2 cycles.
//  2 dec_ready=0 for 5 cycles with inst 0x00500093 held -> next_* stable, no new imem_req_valid, resumes after.
//  3 Redirect to 0x100 in S_WAIT; old rsp 0xDEADBEEF arrives 3 cycles later -> dropped; next req addr 0x100.
//  4 Redirect to 0x203 same cycle as rsp_valid -> rsp dropped, next_valid=0, next req addr 0x200.
//  5 imem_req_ready=0 for 4 cycles -> req_valid and addr 0x0 held steady; handshake on cycle 5.
//  6 Redirect to 0xFFFF_FFFC, rsp 0x13 -> next_pc_reg=0xFFFF_FFFC; next req addr wraps to 0x0.
//  7 rst_n low during S_WAIT -> next_valid=0, next_inst=NOP; first req after release at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the NOP word and the default reset PC.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register: redirect beats sequential advance, and every
// value loaded is forced onto a word boundary.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  input  logic [XLEN-1:0] advance_pc,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_next;

  // A response's pc+4 must never win over a redirect in the same cycle.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc & ALIGN_MASK;
    end else if (advance) begin
      pc_next = advance_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem reads, a registered
// instruction/PC pair for decode, and redirect-driven flushing.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               ILEN     = ILEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            next_valid,
  output logic [XLEN-1:0] next_pc_reg,
  output logic [ILEN-1:0] next_inst
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and payload is stable while valid && !ready.

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            kill;
  logic            kill_next;
  logic            free;
  logic            req_valid_raw;
  logic            req_fire;
  logic            load;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  assign free = !next_valid || dec_ready;

  always_comb begin
    state_next    = state;
    kill_next     = kill;
    req_valid_raw = 1'b0;
    load          = 1'b0;
    case (state)
      S_REQ: begin
        req_valid_raw = free;
        if (req_valid_raw && imem_req_ready) begin
          state_next = S_WAIT;
          // Redirect in the handshake cycle: the old-PC request is already out.
          kill_next  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = S_REQ;
          kill_next  = 1'b0;
          load       = !kill && !redirect_valid;
        end else if (redirect_valid) begin
          kill_next = 1'b1;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  assign imem_req_valid = rst_n && req_valid_raw;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_REQ;
      kill   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
      if (req_fire) begin
        req_pc <= pc;
      end
    end
  end

  // Output register: a redirect flushes, a load fills, a consume empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_valid  <= 1'b0;
      next_pc_reg <= '0;
      next_inst   <= ILEN'(NOP_INST);
    end else if (redirect_valid) begin
      next_valid <= 1'b0;
    end else if (load) begin
      next_valid  <= 1'b1;
      next_pc_reg <= req_pc;
      next_inst   <= imem_rsp_data;
    end else if (next_valid && dec_ready) begin
      next_valid <= 1'b0;
    end
  end

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load),
    .advance_pc     (req_pc),
    .pc             (pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reactive imem model, a reference
// model of PC/kill behaviour and a scoreboard of expected decoder handoffs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        next_valid;
  logic [31:0] next_pc_reg;
  logic [31:0] next_inst;

  fetch_unit #(
    .XLEN     (32),
    .ILEN     (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .next_valid     (next_valid),
    .next_pc_reg    (next_pc_reg),
    .next_inst      (next_inst)
  );

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  bit          pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          wait_cnt  = 0;
  int          lat       = 1;
  bit          use_ovr   = 1'b0;
  logic [31:0] ovr_data  = '0;
  logic [31:0] m_pc      = RESET_PC;
  bit          m_kill    = 1'b0;
  bit          chk_rst   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[17:2]};
  endfunction

  // One clock cycle: drive imem response, check outputs, advance the model.
  task automatic cycle();
    bit pushed;
    imem_rsp_valid = pend && (wait_cnt == 0);
    imem_rsp_data  = use_ovr ? ovr_data : mem_word(pend_addr);
    #1;
    if (chk_rst) begin
      check("rst_next_inst", next_inst, NOP);
      check("rst_next_pc", next_pc_reg, 32'h0);
      chk_rst = 1'b0;
    end
    check("req_valid", {31'b0, imem_req_valid},
          {31'b0, rst_n && !pend && (exp_pc_q.size() == 0 || dec_ready)});
    if (imem_req_valid) begin
      check("req_addr", imem_req_addr, m_pc);
      check("req_addr_align", {30'b0, imem_req_addr[1:0]}, 32'h0);
    end
    check("next_valid", {31'b0, next_valid}, {31'b0, exp_pc_q.size() != 0});
    if (exp_pc_q.size() != 0) begin
      check("next_pc_reg", next_pc_reg, exp_pc_q[0]);
      check("next_inst", next_inst, exp_inst_q[0]);
    end

    if (!rst_n) begin
      pend = 1'b0; m_kill = 1'b0; m_pc = RESET_PC; chk_rst = 1'b1;
      exp_pc_q.delete(); exp_inst_q.delete();
    end else begin
      pushed = 1'b0;
      if (next_valid && dec_ready && exp_pc_q.size() != 0) begin
        void'(exp_pc_q.pop_front()); void'(exp_inst_q.pop_front());
      end
      if (redirect_valid) begin
        exp_pc_q.delete(); exp_inst_q.delete();
      end
      if (imem_rsp_valid) begin
        pend = 1'b0;
        if (!m_kill && !redirect_valid) begin
          exp_pc_q.push_back(pend_addr);
          exp_inst_q.push_back(imem_rsp_data);
          pushed = 1'b1;
        end
        m_kill = 1'b0;
      end else if (pend) begin
        if (wait_cnt != 0) wait_cnt--;
        if (redirect_valid) m_kill = 1'b1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1; pend_addr = m_pc; wait_cnt = lat - 1;
        if (redirect_valid) m_kill = 1'b1;
      end
      if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
      else if (pushed) m_pc = pend_addr + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  // Drain any pending request, then wait for a fresh handshake (DUT in S_WAIT).
  task automatic wait_req(input int budget);
    int n = 0;
    while (pend && n < budget) begin cycle(); n++; end
    while (!pend && n < budget) begin cycle(); n++; end
    check("wait_req_budget", {31'b0, pend}, 32'h1);
  endtask

  task automatic wait_req_valid(input int budget);
    int n = 0;
    while (!imem_req_valid && n < budget) begin cycle(); n++; end
    check("wait_req_valid_budget", {31'b0, imem_req_valid}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run(2);
    rst_n = 1'b1;

    // Sequential fetch: addresses 0,4,8,... one instruction every two cycles.
    run(12);

    // Decoder stall holding 0x00500093.
    use_ovr = 1'b1; ovr_data = 32'h0050_0093;
    run(2);
    dec_ready = 1'b0;
    run(7);
    dec_ready = 1'b1;
    use_ovr = 1'b0;
    run(6);

    // Redirect in S_WAIT; stale 0xDEADBEEF arrives three cycles later.
    lat = 4;
    wait_req(20);
    use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF;
    redirect_to(32'h0000_0100);
    run(3);
    use_ovr = 1'b0;
    run(6);

    // Redirect to an unaligned target in the response cycle.
    lat = 1;
    wait_req(20);
    redirect_to(32'h0000_0203);
    run(6);

    // Second redirect while the first kill is still pending.
    lat = 4;
    wait_req(20);
    redirect_to(32'h0000_0300);
    cycle();
    redirect_to(32'h0000_0400);
    run(8);

    // Redirect coinciding with a request handshake.
    lat = 2;
    wait_req(20);
    wait_req_valid(20);
    redirect_to(32'h0000_0500);
    run(8);

    // Redirect to the top word; the following PC wraps to zero.
    lat = 1;
    imem_req_ready = 1'b0;
    redirect_to(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    use_ovr = 1'b1; ovr_data = 32'h0000_0013;
    wait_req(20);
    cycle();
    use_ovr = 1'b0;
    run(6);

    // Reset during S_WAIT, then imem back-pressure for four cycles.
    lat = 4;
    wait_req(20);
    cycle();
    rst_n = 1'b0; imem_req_ready = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(4);
    imem_req_ready = 1'b1;
    run(6);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      cycle();
    end
    redirect_valid = 1'b0;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
